// File: rtl/uart_tx_apply.sv
// uart_tx_apply: self-running UART transmit source.
// A period timer fires every CNT_10MS clocks. Each firing requests one 8N1 frame
// carrying an incrementing byte, sent through the embedded transmitter u1_uart_tx.
// Ticks that arrive while a request is already outstanding collapse into it.

// uart_tx: 8N1 serial transmitter, BAUD_CNT clocks per bit, LSB first, registered tx.
module uart_tx #(
    parameter int BAUD_CNT = 434
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy
);
    localparam int CW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    // State register: tx idles high and the frame is dropped while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; tx_d is the line level of the cycle being entered,
    // so the pin comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    data_d  = tx_data;
                    state_d = START;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = data_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = busy_q;
endmodule

module uart_tx_apply #(
    parameter int CNT_10MS = 500000,
    parameter int BAUD_CNT = 434
) (
    input  logic clk,
    input  logic rst,              // asynchronous, active-low
    output logic tx
);
    localparam int TW = (CNT_10MS > 1) ? $clog2(CNT_10MS) : 1;
    localparam logic [TW-1:0] CNT_LAST = TW'(CNT_10MS - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          pending_q, pending_d;
    logic          start_q, start_d;
    logic [7:0]    data_ctr_q, data_ctr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          busy;
    logic          issue;

    // Timer, request and payload registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            pending_q  <= 1'b0;
            start_q    <= 1'b0;
            data_ctr_q <= 8'h00;
            tx_data_q  <= 8'h00;
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            pending_q  <= pending_d;
            start_q    <= start_d;
            data_ctr_q <= data_ctr_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Request logic. start_q is excluded from issue because busy only rises the
    // cycle after the transmitter sees tx_start; a tick landing on the start
    // cycle leaves pending set for the next frame instead of a lost second start.
    always_comb begin
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        tick_d     = (cnt_q == CNT_LAST);
        issue      = pending_q && !busy && !start_q;
        start_d    = issue;
        pending_d  = pending_q;
        data_ctr_d = data_ctr_q;
        tx_data_d  = tx_data_q;
        if (issue) begin
            pending_d  = 1'b0;
            data_ctr_d = data_ctr_q + 8'd1;
            tx_data_d  = data_ctr_q;
        end
        if (tick_q) begin
            pending_d = 1'b1;
        end
    end

    uart_tx #(
        .BAUD_CNT(BAUD_CNT)
    ) u1_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .tx_start(start_q),
        .tx_data (tx_data_q),
        .tx      (tx),
        .busy    (busy)
    );
endmodule

// File: tb/tb_uart_tx_apply.sv
// Bench for uart_tx_apply with CNT_10MS=50, BAUD_CNT=10, 20 ns clock.
// Expected payloads are queued when reset is released and popped per decoded frame.
module tb_uart_tx_apply;
    logic clk;
    logic rst;
    logic tx;

    int vec_count = 0;
    int miscompare_count = 0;
    logic [7:0] exp_q[$];
    int frame_no = 0;

    uart_tx_apply #(
        .CNT_10MS(50),
        .BAUD_CNT(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx (tx)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompare_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for a start bit (counting idle-high cycles), then capture 100 samples,
    // one per cycle on the falling clock edge, starting with the first low sample.
    task automatic rx_frame(output logic [99:0] s, output int gap, output bit found);
        s = '1;
        gap = 0;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            gap++;
        end
        if (found) begin
            s[0] = tx;
            for (int i = 1; i < 100; i++) begin
                @(negedge clk);
                s[i] = tx;
            end
        end
    endtask

    task automatic check_frame(input logic [99:0] s, input int gap, input bit found, input bit first);
        logic [7:0] b;
        logic [7:0] exp;
        logic [9:0] mid;
        bit stable;
        int low_run;
        check("rx_found", found, 1);
        check("sb_nonempty", (exp_q.size() != 0), 1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mid[k] = s[10*k + 4];
            for (int j = 0; j < 10; j++)
                if (s[10*k + j] !== s[10*k + 4]) stable = 1'b0;
        end
        b = mid[8:1];
        low_run = 0;
        for (int i = 0; i < 100; i++) begin
            if (s[i] !== 1'b0) break;
            low_run++;
        end
        check("start_bit", mid[0], 0);
        check("payload", b, exp);
        check("stop_bit_full", s[99:90], 10'h3FF);
        check("bit_stable", stable, 1);
        if (first)
            check("first_fall_gap_ok", (gap >= 50 && gap <= 54), 1);
        else
            check("b2b_gap_ok", (gap >= 1 && gap <= 2), 1);
        if (exp == 8'h00)
            check("low_span", low_run, 90);
        if (exp == 8'h05)
            check("bits_0x05", mid, 10'b1000001010);
        $display("frame %0d: got 0x%02h exp 0x%02h gap %0d", frame_no, b, exp, gap);
        frame_no++;
    endtask

    initial begin
        logic [99:0] s;
        int gap;
        bit found;
        bit seen;

        // Power-on reset
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_tx", tx, 1);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));

        // First frames: latency, zero frame, overrun back-to-back, 0x05 bit timing
        for (int f = 0; f < 8; f++) begin
            rx_frame(s, gap, found);
            check_frame(s, gap, found, (f == 0));
        end

        // Reset in the middle of frame 0x08, during data bit 2 (a low bit)
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check("mid_found", seen, 1);
        repeat (30) @(negedge clk);
        check("pre_rst_tx", tx, 0);
        #3 rst = 1'b0;
        #1 check("rst_async_tx", tx, 1);
        @(negedge clk);
        check("rst_hold_tx", tx, 1);
        rst = 1'b1;
        $display("reset pulse applied mid-frame");
        exp_q.delete();
        for (int i = 0; i < 258; i++) exp_q.push_back(8'(i));

        // Restart from 0x00 and run through the 0xFF -> 0x00 wrap
        for (int f = 0; f < 258; f++) begin
            rx_frame(s, gap, found);
            check_frame(s, gap, found, (f == 0));
        end
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end
endmodule
